pc_stack: RTL
=============

// Module: pc_stack
// PURPOSE
//   Parametrised program counter with a hardware return-address stack.
//   Extends the single-bit load register to a WIDTH-bit register with load,
//   increment, call and return modes, plus overflow/underflow error flags.
//   Drives the instruction-memory address in the CPU datapath.
// PARAMETERS
//   WIDTH  16  PC and return-address width in bits
//   DEPTH   8  return-stack entries (>=1)
//   STEP    1  increment amount applied by inc and by call's return address
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   in         in   WIDTH  jump / call target
//   load       in   1      out <= in
//   inc        in   1      out <= out + STEP
//   call       in   1      push out+STEP, out <= in
//   ret        in   1      pop top into out
//   out        out  WIDTH  current PC
//   top        out  WIDTH  current stack top; 0 when empty
//   sp         out  $clog2(DEPTH+1)  entries in use, 0..DEPTH
//   full       out  1      sp == DEPTH (combinational from sp)
//   empty      out  1      sp == 0 (combinational from sp)
//   overflow   out  1      sticky: call attempted while full
//   underflow  out  1      sticky: ret attempted while empty
// BEHAVIOUR
//   - Reset is asynchronous, active-high, and takes effect immediately.
//     While reset is high: out=0, sp=0, overflow=0, underflow=0.
//     Stack RAM contents are not cleared; top reads 0 because sp=0.
//   - Synchronous priority on each rising clk edge, highest first:
//     ret > call > load > inc > hold. Only the winning action executes.
//   - ret, sp>0:   out <= stack[sp-1]; sp <= sp-1.
//   - ret, sp==0:  out holds; underflow <= 1.
//   - call, sp<DEPTH: stack[sp] <= out+STEP; sp <= sp+1; out <= in.
//   - call, sp==DEPTH: the jump still occurs (out <= in).
//     Stack and sp are unchanged. overflow <= 1.
//   - load: out <= in. inc: out <= out+STEP. hold: out unchanged.
//   - Arithmetic is modulo 2^WIDTH; out+STEP wraps with no flag.
//   - call and ret in the same cycle: ret executes; call is dropped and does
//     not set overflow.
//   - Every update is visible on out, top and sp one cycle after the edge.
//     There is no combinational path from any input to out.
//   - overflow and underflow are cleared only by reset.
//   - Reset asserted mid-sequence aborts any pending action; the stack is
//     logically emptied.
// TESTING
//   1. Assert reset mid-cycle with out=0x1234 and sp=3 -> out=0, sp=0, flags=0
//      immediately, before any clk edge.
//   2. Priority: inc=1 for 3 edges -> out=3. Then load=1, inc=1, in=0x0100
//      -> out=0x0100.
//   3. Wrap: load 0xFFFF, then inc -> out=0x0000; no flag set.
//   4. Call/ret: at out=0x0010, call in=0x0200 -> out=0x0200, sp=1,
//      top=0x0011. Then ret -> out=0x0011, sp=0, empty=1.
//   5. Overflow: perform DEPTH+1 calls -> sp=8, full=1, overflow=1.
//      The last call still jumps. Then 8 rets return the correct addresses in
//      LIFO order; a 9th ret sets underflow=1 with out held.
//   6. Simultaneous call=1, ret=1 with sp=2 -> pop only; sp=1; overflow=0.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack.
// ret > call > load > inc > hold; sticky overflow/underflow cleared only by reset.
module pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int STEP  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in,
    input  logic                         load,
    input  logic                         inc,
    input  logic                         call,
    input  logic                         ret,
    output logic [WIDTH-1:0]             out,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] next_seq;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             do_call;
    logic             do_push;
    logic             do_pop;

    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);
    assign next_seq = out + WIDTH'(STEP);
    assign wr_idx   = AW'(sp);
    assign rd_idx   = AW'(sp - SPW'(1));

    // A simultaneous ret swallows the call entirely, including its overflow check.
    assign do_call  = call & ~ret;
    assign do_push  = do_call & ~full;
    assign do_pop   = ret & ~empty;

    assign top = empty ? '0 : stack[rd_idx];

    // Storage has no reset; an empty stack is expressed purely through sp.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            stack[wr_idx] <= next_seq;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (ret) begin
            if (do_pop) begin
                out <= stack[rd_idx];
                sp  <= sp - SPW'(1);
            end else begin
                underflow <= 1'b1;
            end
        end else if (do_call) begin
            out <= in;
            if (do_push) begin
                sp <= sp + SPW'(1);
            end else begin
                overflow <= 1'b1;
            end
        end else if (load) begin
            out <= in;
        end else if (inc) begin
            out <= next_seq;
        end
    end

endmodule
